// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with EX-side operand forwarding and load-use stall detection
module id_ex_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [4:0]      id_rs1,
    input  logic [4:0]      id_rs2,
    input  logic [4:0]      id_rd,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [3:0]      id_alusel,
    input  logic            id_alu_src_imm,
    input  logic [1:0]      id_use_rs,
    input  logic [2:0]      id_ctrl,
    input  logic [4:0]      exmem_rd,
    input  logic            exmem_reg_write,
    input  logic [XLEN-1:0] exmem_result,
    input  logic [4:0]      memwb_rd,
    input  logic            memwb_reg_write,
    input  logic [XLEN-1:0] memwb_result,
    output logic            ex_valid,
    output logic [4:0]      ex_rd,
    output logic [2:0]      ex_ctrl,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [4:0]      alu_shamt,
    output logic [3:0]      alu_sel,
    output logic [XLEN-1:0] ex_store_data,
    output logic            load_use_stall
);
    logic            r_valid;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_rs1_data;
    logic [XLEN-1:0] r_rs2_data;
    logic [XLEN-1:0] r_imm;
    logic [3:0]      r_alusel;
    logic            r_alu_src_imm;
    logic [2:0]      r_ctrl;
    logic            ex_hit1, wb_hit1, ex_hit2, wb_hit2;
    logic [XLEN-1:0] fwd_rs1, fwd_rs2;
    always_comb begin
        load_use_stall = id_valid & r_valid & r_ctrl[1] & (r_rd != 5'd0) &
                         ((id_use_rs[0] & (id_rs1 == r_rd)) | (id_use_rs[1] & (id_rs2 == r_rd)));
        ex_hit1 = exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == r_rs1);
        wb_hit1 = memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == r_rs1);
        ex_hit2 = exmem_reg_write & (exmem_rd != 5'd0) & (exmem_rd == r_rs2);
        wb_hit2 = memwb_reg_write & (memwb_rd != 5'd0) & (memwb_rd == r_rs2);
        fwd_rs1 = ex_hit1 ? exmem_result : wb_hit1 ? memwb_result : r_rs1_data;
        fwd_rs2 = ex_hit2 ? exmem_result : wb_hit2 ? memwb_result : r_rs2_data;
        alu_a = fwd_rs1;
        alu_b = r_alu_src_imm ? r_imm : fwd_rs2;
        alu_shamt = alu_b[4:0];
        alu_sel = r_alusel;
        ex_store_data = fwd_rs2;
        ex_valid = r_valid;
        ex_rd = r_rd;
        ex_ctrl = r_ctrl;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid       <= 1'b0;
            r_rs1         <= '0;
            r_rs2         <= '0;
            r_rd          <= '0;
            r_rs1_data    <= '0;
            r_rs2_data    <= '0;
            r_imm         <= '0;
            r_alusel      <= '0;
            r_alu_src_imm <= 1'b0;
            r_ctrl        <= '0;
        end else if (flush || load_use_stall) begin
            // bubble: only the control-visible fields are cleared
            r_valid  <= 1'b0;
            r_ctrl   <= '0;
            r_alusel <= '0;
        end else begin
            r_valid       <= id_valid;
            r_rs1         <= id_rs1;
            r_rs2         <= id_rs2;
            r_rd          <= id_rd;
            r_rs1_data    <= id_rs1_data;
            r_rs2_data    <= id_rs2_data;
            r_imm         <= id_imm;
            r_alusel      <= id_alusel;
            r_alu_src_imm <= id_alu_src_imm;
            r_ctrl        <= id_valid ? id_ctrl : 3'b000;
        end
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed vectors with a queue-based scoreboard checked on the falling edge
module tb_id_ex_stage;
    localparam int XLEN = 32;
    logic            clk = 1'b0;
    logic            rst_n, flush, id_valid, id_alu_src_imm;
    logic [4:0]      id_rs1, id_rs2, id_rd, exmem_rd, memwb_rd;
    logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm, exmem_result, memwb_result;
    logic [3:0]      id_alusel;
    logic [1:0]      id_use_rs;
    logic [2:0]      id_ctrl;
    logic            exmem_reg_write, memwb_reg_write;
    logic            ex_valid, load_use_stall;
    logic [4:0]      ex_rd, alu_shamt;
    logic [2:0]      ex_ctrl;
    logic [XLEN-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]      alu_sel;

    typedef struct {
        string       nm;
        logic        stall, vld;
        logic [2:0]  ctrl;
        logic [4:0]  rd, sh;
        logic [3:0]  sel;
        logic [31:0] a, b, sd;
        bit          cs, cd;
    } exp_t;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;

    id_ex_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_alusel(id_alusel), .id_alu_src_imm(id_alu_src_imm), .id_use_rs(id_use_rs),
        .id_ctrl(id_ctrl), .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write),
        .exmem_result(exmem_result), .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write),
        .memwb_result(memwb_result), .ex_valid(ex_valid), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
        .alu_a(alu_a), .alu_b(alu_b), .alu_shamt(alu_shamt), .alu_sel(alu_sel),
        .ex_store_data(ex_store_data), .load_use_stall(load_use_stall)
    );

    always #5 clk = ~clk;

    task automatic id(input logic v, input logic [4:0] rs1, rs2, rd, input logic [31:0] d1, d2, imm,
                      input logic [3:0] sel, input logic simm, input logic [1:0] use_rs, input logic [2:0] ctrl);
        id_valid = v; id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = imm;
        id_alusel = sel; id_alu_src_imm = simm; id_use_rs = use_rs; id_ctrl = ctrl;
    endtask

    task automatic fw(input logic [4:0] erd, input logic ew, input logic [31:0] eres,
                      input logic [4:0] mrd, input logic mw, input logic [31:0] mres);
        exmem_rd = erd; exmem_reg_write = ew; exmem_result = eres;
        memwb_rd = mrd; memwb_reg_write = mw; memwb_result = mres;
    endtask

    // push what the outputs must show this cycle, then advance past the next rising edge
    task automatic step(input string nm, input logic stall, vld, input logic [2:0] ctrl,
                        input logic [4:0] rd, input logic [3:0] sel, input logic [31:0] a, b, sd,
                        input logic [4:0] sh, input bit cs, cd);
        exp_t e;
        e.nm = nm; e.stall = stall; e.vld = vld; e.ctrl = ctrl; e.rd = rd; e.sel = sel;
        e.a = a; e.b = b; e.sd = sd; e.sh = sh; e.cs = cs; e.cd = cd;
        q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            bit bad;
            e = q.pop_front();
            n_vec++;
            bad = (load_use_stall !== e.stall) || (ex_valid !== e.vld) || (ex_ctrl !== e.ctrl) ||
                  (e.cs && alu_sel !== e.sel) ||
                  (e.cd && (ex_rd !== e.rd || alu_a !== e.a || alu_b !== e.b ||
                            ex_store_data !== e.sd || alu_shamt !== e.sh));
            if (bad) begin
                n_err++;
                $display("FAIL %s: got stall=%b vld=%b ctrl=%b rd=%0d sel=%h a=%h b=%h sd=%h sh=%0d | want stall=%b vld=%b ctrl=%b rd=%0d sel=%h a=%h b=%h sd=%h sh=%0d (sel chk %0d, data chk %0d)",
                         e.nm, load_use_stall, ex_valid, ex_ctrl, ex_rd, alu_sel, alu_a, alu_b,
                         ex_store_data, alu_shamt, e.stall, e.vld, e.ctrl, e.rd, e.sel, e.a, e.b,
                         e.sd, e.sh, e.cs, e.cd);
            end
        end
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0;
        id(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b00, 3'b100);
        fw(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        id(1, 1, 2, 4, 32'd5, 32'd7, 0, 4'h0, 0, 2'b11, 3'b100);
        step("reset", 0, 0, 3'b000, 0, 4'h0, 0, 0, 0, 0, 1, 1);
        id(1, 0, 0, 5, 0, 0, 32'd8, 4'h0, 1, 2'b01, 3'b110);
        step("capture", 0, 1, 3'b100, 4, 4'h0, 32'd5, 32'd7, 32'd7, 5'd7, 1, 1);
        id(1, 5, 0, 6, 32'h11, 0, 0, 4'h0, 0, 2'b01, 3'b100);
        step("load_use_stall", 1, 1, 3'b110, 5, 4'h0, 0, 32'd8, 0, 5'd8, 1, 1);
        step("load_use_bubble", 0, 0, 3'b000, 0, 4'h0, 0, 0, 0, 0, 1, 0);
        id(1, 3, 0, 7, 32'h33, 32'h44, 0, 4'h2, 0, 2'b11, 3'b100);
        step("after_stall", 0, 1, 3'b100, 6, 4'h0, 32'h11, 0, 0, 0, 1, 1);
        fw(3, 1, 32'hAAAA, 3, 1, 32'hBBBB);
        step("fwd_exmem_prio", 0, 1, 3'b100, 7, 4'h2, 32'hAAAA, 32'h44, 32'h44, 5'd4, 1, 1);
        exmem_reg_write = 1'b0;
        step("fwd_memwb", 0, 1, 3'b100, 7, 4'h2, 32'hBBBB, 32'h44, 32'h44, 5'd4, 1, 1);
        fw(0, 1, 32'hAAAA, 0, 1, 32'hBBBB);
        id(1, 0, 0, 8, 32'h55, 32'h66, 0, 4'h3, 0, 2'b11, 3'b100);
        step("fwd_rd0_miss", 0, 1, 3'b100, 7, 4'h2, 32'h33, 32'h44, 32'h44, 5'd4, 1, 1);
        id(1, 0, 9, 10, 32'h1, 32'h99, 32'hFFFF_FFE3, 4'h8, 1, 2'b01, 3'b100);
        step("x0_no_fwd", 0, 1, 3'b100, 8, 4'h3, 32'h55, 32'h66, 32'h66, 5'd6, 1, 1);
        fw(9, 1, 32'h1234, 0, 0, 0);
        id(1, 0, 0, 5, 0, 0, 0, 4'h0, 1, 2'b00, 3'b110);
        step("imm_shamt", 0, 1, 3'b100, 10, 4'h8, 32'h1, 32'hFFFF_FFE3, 32'h1234, 5'd3, 1, 1);
        fw(0, 0, 0, 0, 0, 0);
        id(1, 5, 0, 11, 32'h77, 0, 0, 4'h0, 0, 2'b00, 3'b100);
        step("load_no_use", 0, 1, 3'b110, 5, 4'h0, 0, 0, 0, 0, 1, 1);
        id(1, 0, 0, 5, 0, 0, 0, 4'h0, 1, 2'b00, 3'b110);
        step("no_stall_capture", 0, 1, 3'b100, 11, 4'h0, 32'h77, 0, 0, 0, 1, 1);
        id(1, 5, 0, 12, 0, 0, 0, 4'h0, 0, 2'b01, 3'b100);
        flush = 1'b1;
        step("flush_and_stall", 1, 1, 3'b110, 5, 4'h0, 0, 0, 0, 0, 1, 1);
        flush = 1'b0;
        id(1, 0, 0, 13, 32'h13, 0, 0, 4'h5, 0, 2'b01, 3'b100);
        step("single_bubble", 0, 0, 3'b000, 0, 4'h0, 0, 0, 0, 0, 1, 0);
        id(1, 0, 0, 14, 32'h14, 0, 0, 4'h6, 0, 2'b01, 3'b100);
        flush = 1'b1;
        step("pre_flush", 0, 1, 3'b100, 13, 4'h5, 32'h13, 0, 0, 0, 1, 1);
        flush = 1'b0;
        id(0, 0, 0, 15, 0, 0, 0, 4'h7, 0, 2'b00, 3'b100);
        step("flush_bubble", 0, 0, 3'b000, 0, 4'h0, 0, 0, 0, 0, 1, 0);
        id(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 2'b00, 3'b000);
        step("invalid_ctrl_zero", 0, 0, 3'b000, 0, 4'h0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
            n_err++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
